branch_predict_judge: RTL and testbench
=======================================

// Module: branch_predict_judge
// PURPOSE
//  Parametrised successor to the ID-stage branch comparator. Resolves the branch
//  condition on XLEN-bit operands and registers the outcome. Also holds a BHT_DEPTH-entry
//  table of 2-bit saturating counters, which the IF stage reads for a taken/not-taken
//  prediction. Flags mispredicts and keeps saturating branch/mispredict statistics.
// PARAMETERS
//  XLEN      32  operand and PC width
//  BHT_DEPTH 64  predictor entries; power of two, >=2
//  CNT_W     32  statistics counter width
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous active-low reset
//  lookup_pc     in   XLEN     IF-stage PC for prediction lookup
//  pred_taken    out  1        combinational prediction = bht[idx(lookup_pc)][1]
//  res_valid     in   1        resolve-side branch present this cycle
//  stall         in   1        pipeline stall; blocks resolve and all state updates
//  res_pc        in   XLEN     PC of the branch being resolved
//  rega          in   XLEN     operand A
//  regb          in   XLEN     operand B
//  branch_cond   in   3        0 none,1 eq,2 ne,3 lez,4 gtz,5 ltz,6 gez,7 always
//  res_pred      in   1        prediction that was made for this branch in IF
//  b             out  1        registered actual-taken result
//  out_valid     out  1        registered: b/mispredict valid this cycle
//  mispredict    out  1        registered: out_valid & (b != res_pred)
//  br_cnt        out  CNT_W    resolved conditional branches (codes 1-6)
//  mp_cnt        out  CNT_W    mispredicts counted
// BEHAVIOUR
//  - idx(pc) = pc[IDX_W+1:2], IDX_W = $clog2(BHT_DEPTH); word-aligned PCs.
//  - Condition decode (signed view of rega): eq  rega==regb; ne  rega!=regb;
//    lez  rega[XLEN-1] | (rega==0); gtz  ~rega[XLEN-1] & (rega!=0);
//    ltz  rega[XLEN-1]; gez  ~rega[XLEN-1]; always  1; none  0.
//  - Accept = res_valid & ~stall & (branch_cond!=0).
//  - Edge after accept: b<=taken, out_valid<=1, mispredict<=(taken!=res_pred).
//  - Cycle with no accept: out_valid<=0, mispredict<=0, b holds its last value.
//  - Latency: one cycle from accept to out_valid.
//  - Stall: all registers, counters and the BHT hold their values.
//  - BHT update on accept, codes 1-6 only. Code 7 never trains the table.
//    Taken: counter increments, saturating at 2'b11. Not taken: decrements,
//    saturating at 2'b00.
//  - Lookup/update hazard: same index in the same cycle returns the pre-update
//    counter; no bypass.
//  - br_cnt increments on accept with codes 1-6.
//  - mp_cnt increments on accept when taken!=res_pred, code 7 included.
//  - Both counters saturate at all-ones and never wrap.
//  - Reset: asynchronous, effective immediately, including mid-operation.
//    All BHT entries <= 2'b01 (weakly not-taken); b, out_valid, mispredict <= 0;
//    br_cnt, mp_cnt <= 0.
//  - pred_taken is therefore 0 during and after reset until training occurs.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> b=out_valid=mispredict=0, counters 0,
//    pred_taken=0 for any lookup_pc.
//  2 Decode sweep, XLEN=32, res_pred=0:
//    - eq/ne, rega=regb=5 -> b=1/0.
//    - lez, rega=0 -> 1. gtz, rega=0 -> 0. ltz, 0x80000000 -> 1.
//    - gez, 0x80000000 -> 0. code 7 -> 1, mispredict=1.
//  3 Training at res_pc=0x40:
//    - Taken twice -> counter 11, pred_taken=1 at lookup_pc=0x40.
//    - Then not taken x3 -> counter 00, pred_taken=0.
//    - A fourth not-taken leaves the counter at 00.
//  4 Aliasing and hazard (BHT_DEPTH=64):
//    - res_pc 0x40 and 0x140 share an entry.
//    - Same-cycle lookup and taken update of that index -> pred_taken shows the
//      old value; new value visible the next cycle.
//  5 Stall and stats:
//    - Accept with stall=1 -> no out_valid, BHT and counters unchanged.
//    - Set CNT_W=4 and run 20 mispredicting branches -> br_cnt=mp_cnt=15,
//      saturated.

Source files
------------

// File: rtl/branch_predict_judge_if.sv
// Interface bundling the IF-stage lookup, the resolve-side inputs and the
// registered resolve results of the branch judge.
interface branch_predict_judge_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  lookup_pc;
    logic             pred_taken;
    logic             res_valid;
    logic             stall;
    logic [XLEN-1:0]  res_pc;
    logic [XLEN-1:0]  rega;
    logic [XLEN-1:0]  regb;
    logic [2:0]       branch_cond;
    logic             res_pred;
    logic             b;
    logic             out_valid;
    logic             mispredict;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    // Pipeline side: drives lookups and branches to resolve.
    modport master (
        output lookup_pc, res_valid, stall, res_pc, rega, regb, branch_cond, res_pred,
        input  pred_taken, b, out_valid, mispredict, br_cnt, mp_cnt
    );

    // Judge side.
    modport slave (
        input  lookup_pc, res_valid, stall, res_pc, rega, regb, branch_cond, res_pred,
        output pred_taken, b, out_valid, mispredict, br_cnt, mp_cnt
    );
endinterface

// File: rtl/branch_predict_judge.sv
// Branch condition resolver with a 2-bit saturating-counter branch history
// table, mispredict flagging and saturating branch/mispredict statistics.
module branch_predict_judge #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predict_judge_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       bht_r [BHT_DEPTH];
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] res_idx_s;
    logic             taken_s;
    logic             zero_s;
    logic             accept_s;
    logic             train_s;
    logic             mp_inc_s;
    logic [1:0]       bht_cur_s;
    logic [1:0]       bht_next_s;
    logic             b_r;
    logic             out_valid_r;
    logic             mispredict_r;
    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] mp_cnt_r;

    // Word-aligned PCs: drop the two byte-offset bits.
    assign lookup_idx_s = bus.lookup_pc[IDX_W+1:2];
    assign res_idx_s    = bus.res_pc[IDX_W+1:2];

    assign zero_s    = (bus.rega == {XLEN{1'b0}});
    assign accept_s  = bus.res_valid & ~bus.stall & (bus.branch_cond != 3'd0);
    // Unconditional jumps (code 7) are resolved but never train or count as branches.
    assign train_s   = accept_s & (bus.branch_cond != 3'd7);
    assign mp_inc_s  = accept_s & (taken_s != bus.res_pred);
    assign bht_cur_s = bht_r[res_idx_s];

    // Prediction reads the table before any same-cycle update (no bypass).
    assign bus.pred_taken = bht_r[lookup_idx_s][1];
    assign bus.b          = b_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.mispredict = mispredict_r;
    assign bus.br_cnt     = br_cnt_r;
    assign bus.mp_cnt     = mp_cnt_r;

    // Decode the branch condition on the signed view of rega.
    always_comb begin
        taken_s = 1'b0;
        case (bus.branch_cond)
            3'd1:    taken_s = (bus.rega == bus.regb);
            3'd2:    taken_s = (bus.rega != bus.regb);
            3'd3:    taken_s = bus.rega[XLEN-1] | zero_s;
            3'd4:    taken_s = ~bus.rega[XLEN-1] & ~zero_s;
            3'd5:    taken_s = bus.rega[XLEN-1];
            3'd6:    taken_s = ~bus.rega[XLEN-1];
            3'd7:    taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
    end

    // Saturating up/down step of the addressed history counter.
    always_comb begin
        bht_next_s = bht_cur_s;
        if (taken_s) begin
            if (bht_cur_s != 2'b11) begin
                bht_next_s = bht_cur_s + 2'd1;
            end else begin
                bht_next_s = bht_cur_s;
            end
        end else begin
            if (bht_cur_s != 2'b00) begin
                bht_next_s = bht_cur_s - 2'd1;
            end else begin
                bht_next_s = bht_cur_s;
            end
        end
    end

    // Registered resolve result; everything freezes while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_r          <= 1'b0;
            out_valid_r  <= 1'b0;
            mispredict_r <= 1'b0;
        end else if (!bus.stall) begin
            out_valid_r  <= accept_s;
            mispredict_r <= mp_inc_s;
            if (accept_s) begin
                b_r <= taken_s;
            end
        end
    end

    // History table: reset to weakly not-taken, trained by conditional branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (train_s) begin
            bht_r[res_idx_s] <= bht_next_s;
        end
    end

    // Saturating statistics counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_r <= {CNT_W{1'b0}};
            mp_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (train_s && (br_cnt_r != CNT_MAX)) begin
                br_cnt_r <= br_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mp_inc_s && (mp_cnt_r != CNT_MAX)) begin
                mp_cnt_r <= mp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_judge.sv
// Scoreboard bench for branch_predict_judge: stimulus pushes expected
// resolve results, a negedge monitor pops and compares on out_valid.
module tb_branch_predict_judge;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct {
        logic       b;
        logic       mp;
        logic [3:0] br;
        logic [3:0] mpc;
    } exp_t;

    typedef struct {
        logic [2:0]  cond;
        logic [31:0] a;
        logic [31:0] bv;
        logic        taken;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   exp_br = 0;
    int   exp_mp = 0;
    exp_t sb[$];

    branch_predict_judge_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_predict_judge #(.XLEN(XLEN), .BHT_DEPTH(64), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("b", bus.b, e.b);
                check("mispredict", bus.mispredict, e.mp);
                check("br_cnt", bus.br_cnt, e.br);
                check("mp_cnt", bus.mp_cnt, e.mpc);
            end
        end
    end

    // Apply one resolve request and queue its expected outcome.
    task automatic drive(input logic [2:0] cond, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] bv, input logic pred, input logic taken);
        exp_t e;
        bus.res_valid   = 1'b1;
        bus.branch_cond = cond;
        bus.res_pc      = pc;
        bus.rega        = a;
        bus.regb        = bv;
        bus.res_pred    = pred;
        if (cond != 3'd0) begin
            if (cond != 3'd7) exp_br = (exp_br < 15) ? exp_br + 1 : 15;
            if (taken != pred) exp_mp = (exp_mp < 15) ? exp_mp + 1 : 15;
            e.b   = taken;
            e.mp  = (taken != pred);
            e.br  = 4'(exp_br);
            e.mpc = 4'(exp_mp);
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [2:0] cond, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] bv, input logic pred, input logic taken);
        drive(cond, pc, a, bv, pred, taken);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
    endtask

    vec_t sweep[10] = '{
        '{3'd1, 32'd5,          32'd5, 1'b1},
        '{3'd2, 32'd5,          32'd5, 1'b0},
        '{3'd3, 32'd0,          32'd0, 1'b1},
        '{3'd4, 32'd0,          32'd0, 1'b0},
        '{3'd5, 32'h8000_0000,  32'd0, 1'b1},
        '{3'd6, 32'h8000_0000,  32'd0, 1'b0},
        '{3'd4, 32'd5,          32'd0, 1'b1},
        '{3'd3, 32'hFFFF_FFFF,  32'd0, 1'b1},
        '{3'd1, 32'd5,          32'd6, 1'b0},
        '{3'd7, 32'd0,          32'd0, 1'b1}
    };

    initial begin
        bus.lookup_pc   = 32'h0000_0040;
        bus.res_valid   = 1'b0;
        bus.stall       = 1'b0;
        bus.res_pc      = 32'h0;
        bus.rega        = 32'h0;
        bus.regb        = 32'h0;
        bus.branch_cond = 3'd0;
        bus.res_pred    = 1'b0;

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_b", bus.b, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_mispredict", bus.mispredict, 1'b0);
        check("rst_br_cnt", bus.br_cnt, 4'd0);
        check("rst_mp_cnt", bus.mp_cnt, 4'd0);
        check("rst_pred", bus.pred_taken, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Condition decode sweep at an unrelated PC
        foreach (sweep[i]) issue(sweep[i].cond, 32'h8, sweep[i].a, sweep[i].bv, 1'b0, sweep[i].taken);
        // Code 0 is never accepted and b keeps its last value
        issue(3'd0, 32'h8, 32'd1, 32'd1, 1'b0, 1'b0);
        check("hold_out_valid", bus.out_valid, 1'b0);
        check("hold_b", bus.b, 1'b1);

        // Training at 0x40: 01 -> 10 -> 11
        check("pred_init_40", bus.pred_taken, 1'b0);
        issue(3'd1, 32'h40, 32'd1, 32'd1, 1'b0, 1'b1);
        check("pred_after_t1", bus.pred_taken, 1'b1);
        issue(3'd1, 32'h40, 32'd1, 32'd1, 1'b0, 1'b1);
        check("pred_after_t2", bus.pred_taken, 1'b1);
        // Not taken x3: 11 -> 10 -> 01 -> 00
        issue(3'd1, 32'h40, 32'd1, 32'd2, 1'b0, 1'b0);
        check("pred_after_n1", bus.pred_taken, 1'b1);
        issue(3'd1, 32'h40, 32'd1, 32'd2, 1'b0, 1'b0);
        check("pred_after_n2", bus.pred_taken, 1'b0);
        issue(3'd1, 32'h40, 32'd1, 32'd2, 1'b0, 1'b0);
        check("pred_after_n3", bus.pred_taken, 1'b0);
        // Fourth not-taken must stay at 00
        issue(3'd1, 32'h40, 32'd1, 32'd2, 1'b0, 1'b0);
        check("pred_after_n4", bus.pred_taken, 1'b0);

        // Aliasing: 0x140 trains the 0x40 entry (00 -> 01 -> 10)
        issue(3'd1, 32'h140, 32'd1, 32'd1, 1'b0, 1'b1);
        check("alias_t1", bus.pred_taken, 1'b0);
        issue(3'd1, 32'h140, 32'd1, 32'd1, 1'b0, 1'b1);
        check("alias_t2", bus.pred_taken, 1'b1);
        issue(3'd1, 32'h140, 32'd1, 32'd2, 1'b0, 1'b0);
        check("alias_n1", bus.pred_taken, 1'b0);

        // Hazard: same-cycle lookup sees pre-update 01, next cycle sees 10
        drive(3'd1, 32'h140, 32'd9, 32'd9, 1'b0, 1'b1);
        #2;
        check("hazard_old", bus.pred_taken, 1'b0);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        check("hazard_new", bus.pred_taken, 1'b1);

        // Stall: a not-taken accept attempt must change nothing
        @(posedge clk);
        #1;
        bus.stall       = 1'b1;
        bus.res_valid   = 1'b1;
        bus.branch_cond = 3'd1;
        bus.res_pc      = 32'h40;
        bus.rega        = 32'd1;
        bus.regb        = 32'd2;
        bus.res_pred    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_out_valid", bus.out_valid, 1'b0);
        check("stall_pred", bus.pred_taken, 1'b1);
        check("stall_b", bus.b, 1'b1);
        check("stall_br_cnt", bus.br_cnt, 32'(exp_br));
        check("stall_mp_cnt", bus.mp_cnt, 32'(exp_mp));
        bus.stall     = 1'b0;
        bus.res_valid = 1'b0;
        @(posedge clk);
        #1;

        // Statistics saturation with 20 mispredicting branches
        for (int i = 0; i < 20; i++) issue(3'd1, 32'h8, 32'd7, 32'd7, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("sat_br_cnt", bus.br_cnt, 4'd15);
        check("sat_mp_cnt", bus.mp_cnt, 4'd15);

        // Asynchronous reset while a result is being presented
        issue(3'd1, 32'h40, 32'd3, 32'd3, 1'b0, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        exp_br = 0;
        exp_mp = 0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_b", bus.b, 1'b0);
        check("mid_rst_mispredict", bus.mispredict, 1'b0);
        check("mid_rst_br_cnt", bus.br_cnt, 4'd0);
        check("mid_rst_mp_cnt", bus.mp_cnt, 4'd0);
        check("mid_rst_pred_40", bus.pred_taken, 1'b0);
        bus.lookup_pc = 32'h8;
        #1;
        check("mid_rst_pred_08", bus.pred_taken, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Correctly predicted branch after reset: br=1, mp=0
        issue(3'd5, 32'h8, 32'h8000_0000, 32'd0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
